// File: rtl/aud_adc_capture.sv
// aud_adc_capture
// Receive half of the WM8731 audio link (codec master, I2S, 16-bit slots).
// The codec's BCLK / ADCLRCK / ADCDAT are oversampled in i_clk. One
// left-channel word per frame is presented on a valid/ready port to the
// SRAM writer, at an address that counts up from zero.
//
// Handshake: o_valid rises together with a fresh o_data/o_addr and all three
// hold steady until a cycle with o_valid & i_ready, which is the transfer.
// The only ways o_valid falls without a transfer are i_stop and i_rst.
//
// dbg_state mirrors the FSM state register so that checkers can bind to it:
// 0 IDLE, 1 WAIT_L, 2 SHIFT, 3 PUSH, 4 PAUSED.
module aud_adc_capture #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_AUD_BCLK,
    input  logic              i_AUD_ADCLRCK,
    input  logic              i_AUD_ADCDAT,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_overrun,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_L = 3'd1,
        S_SHIFT  = 3'd2,
        S_PUSH   = 3'd3,
        S_PAUSED = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Two-flop synchronisers; bclk_d is one more stage used only for edge detection.
    logic bclk_s1;
    logic bclk_s2;
    logic bclk_d;
    logic lrck_s1;
    logic lrck_s2;
    logic dat_s1;
    logic dat_s2;

    // LRCK level seen at the previous BCLK rise, for the 1->0 frame marker.
    logic lrck_prev;

    logic bclk_rise;
    logic frame_start;

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shift_word;
    logic [CNT_W-1:0]  bit_cnt;

    // Pause requested while a word is in flight; honoured after its transfer.
    logic pend;

    logic accept;
    logic at_max;

    // FSM decode strobes consumed by the datapath registers.
    logic clr_run;
    logic enter_shift;
    logic shift_en;
    logic load_word;
    logic set_pend;
    logic clr_pend;

    // LRCK and DAT are taken from the same stage as the BCLK edge, so the
    // three codec lines stay mutually aligned after synchronisation.
    assign bclk_rise   = bclk_s2 & ~bclk_d;
    assign frame_start = bclk_rise & lrck_prev & ~lrck_s2;
    assign shift_word  = {shreg[DATA_W-2:0], dat_s2};

    assign accept    = o_valid & i_ready;
    assign at_max    = (o_addr == MAX_ADDR);
    assign o_busy    = (state != S_IDLE);
    assign dbg_state = state;

    // Synchronise the codec lines and remember LRCK at every BCLK rise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bclk_s1   <= 1'b0;
            bclk_s2   <= 1'b0;
            bclk_d    <= 1'b0;
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
            dat_s1    <= 1'b0;
            dat_s2    <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_s1 <= i_AUD_BCLK;
            bclk_s2 <= bclk_s1;
            bclk_d  <= bclk_s2;
            lrck_s1 <= i_AUD_ADCLRCK;
            lrck_s2 <= lrck_s1;
            dat_s1  <= i_AUD_ADCDAT;
            dat_s2  <= dat_s1;
            if (bclk_rise) begin
                lrck_prev <= lrck_s2;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and datapath strobes; stop overrides everything else.
    always_comb begin
        state_next  = state;
        clr_run     = 1'b0;
        enter_shift = 1'b0;
        shift_en    = 1'b0;
        load_word   = 1'b0;
        set_pend    = 1'b0;
        clr_pend    = 1'b0;
        case (state)
            S_IDLE: begin
                // A coincident pause outranks start, so the pair is ignored.
                if (i_start && !i_pause) begin
                    state_next = S_WAIT_L;
                    clr_run    = 1'b1;
                    clr_pend   = 1'b1;
                end
            end
            S_WAIT_L: begin
                if (i_pause) begin
                    state_next = S_PAUSED;
                    clr_pend   = 1'b1;
                end else if (frame_start) begin
                    // This rise is the I2S one-bit delay slot: no data taken.
                    state_next  = S_SHIFT;
                    enter_shift = 1'b1;
                end
            end
            S_SHIFT: begin
                set_pend = i_pause;
                if (bclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = S_PUSH;
                        load_word  = 1'b1;
                    end
                end
            end
            S_PUSH: begin
                set_pend = i_pause;
                if (accept) begin
                    clr_pend = 1'b1;
                    if (at_max) begin
                        state_next = S_IDLE;
                    end else if (pend || i_pause) begin
                        state_next = S_PAUSED;
                    end else begin
                        state_next = S_WAIT_L;
                    end
                end
            end
            S_PAUSED: begin
                if (i_start && !i_pause) begin
                    state_next = S_WAIT_L;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (i_stop) begin
            state_next  = S_IDLE;
            clr_run     = 1'b0;
            enter_shift = 1'b0;
            shift_en    = 1'b0;
            load_word   = 1'b0;
            set_pend    = 1'b0;
            clr_pend    = 1'b1;
        end
    end

    // Serial-to-parallel shift register and bit counter for the left slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (enter_shift) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= shift_word;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Output word, address counter, sticky flags and pending pause.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data    <= '0;
            o_addr    <= '0;
            o_valid   <= 1'b0;
            o_full    <= 1'b0;
            o_overrun <= 1'b0;
            pend      <= 1'b0;
        end else begin
            // Valid exactly while the FSM sits in PUSH; this also drops it on stop.
            o_valid <= (state_next == S_PUSH);
            if (load_word) begin
                o_data <= shift_word;
            end
            if (clr_run) begin
                o_addr    <= '0;
                o_full    <= 1'b0;
                o_overrun <= 1'b0;
            end else begin
                // A transfer counts even if stop arrives in the same cycle,
                // so o_addr stays equal to the number of stored samples.
                if (accept) begin
                    if (at_max) begin
                        o_full <= 1'b1;
                    end else begin
                        o_addr <= o_addr + 1'b1;
                    end
                end
                // A new left frame while still waiting on the writer is lost.
                if (state == S_PUSH && frame_start) begin
                    o_overrun <= 1'b1;
                end
            end
            if (clr_pend) begin
                pend <= 1'b0;
            end else if (set_pend) begin
                pend <= 1'b1;
            end
        end
    end

endmodule
